nios2_jtag_debug_sysclk_bridge: RTL



---
 rtl/nios2_dbg_pkg.sv | 13 +
 rtl/nios2_dbg_sync.sv | 20 ++
 rtl/nios2_jtag_debug_sysclk_bridge.sv | 106 ++++++++++
 3 files changed

// File: rtl/nios2_dbg_pkg.sv
// Shared constants and types for the Nios II JTAG debug sysclk bridge.
package nios2_dbg_pkg;

    localparam int unsigned SR_W_DEF   = 38;
    localparam int unsigned IR_W_DEF   = 2;
    localparam int unsigned ACTION_BIT = SR_W_DEF - 1;

    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [SR_W_DEF-1:0] sr;
    } cmd_entry_t;

endpackage

// File: rtl/nios2_dbg_sync.sv
// Single-bit multi-stage synchroniser with asynchronous active-high reset.
module nios2_dbg_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/nios2_jtag_debug_sysclk_bridge.sv
// System-clock side of the JTAG debug path: syncs TCK strobes, queues captured
// commands and issues per-channel action/no-action strobes under cmd_ready.
module nios2_jtag_debug_sysclk_bridge
    import nios2_dbg_pkg::*;
#(
    parameter int unsigned SR_W        = SR_W_DEF,
    parameter int unsigned IR_W        = IR_W_DEF,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vs_udr,
    input  logic                  vs_uir,
    input  logic                  jtag_rti,
    input  logic [IR_W-1:0]       ir_in,
    input  logic [SR_W-1:0]       sr,
    input  logic                  cmd_ready,
    input  logic                  ovf_clr,
    output logic [SR_W-1:0]       jdo,
    output logic [IR_W-1:0]       cmd_ir,
    output logic [(1<<IR_W)-1:0]  take_action,
    output logic [(1<<IR_W)-1:0]  take_no_action,
    output logic                  ir_update,
    output logic                  st_ready_test_idle,
    output logic                  cmd_pending,
    output logic                  overflow
);

    localparam int unsigned NCH = 1 << IR_W;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] sr;
    } entry_t;

    logic udr_s, uir_s, rti_s;
    logic udr_q, uir_q;

    nios2_dbg_sync #(.STAGES(SYNC_STAGES)) u_sync_udr (.clk(clk), .rst(reset), .d(vs_udr),   .q(udr_s));
    nios2_dbg_sync #(.STAGES(SYNC_STAGES)) u_sync_uir (.clk(clk), .rst(reset), .d(vs_uir),   .q(uir_s));
    nios2_dbg_sync #(.STAGES(SYNC_STAGES)) u_sync_rti (.clk(clk), .rst(reset), .d(jtag_rti), .q(rti_s));

    assign st_ready_test_idle = rti_s;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          udr_rise, full, pop, push_ok, ovf_set;
    logic [NCH-1:0] head_onehot;

    assign udr_rise    = udr_s & ~udr_q;
    assign full        = (count == CW'(DEPTH));
    assign cmd_pending = (count != '0);
    assign pop         = cmd_pending & cmd_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok     = udr_rise & (~full | pop);
    assign ovf_set     = udr_rise & full & ~pop;
    assign head        = mem[rd_ptr];
    assign head_onehot = NCH'(1) << head.ir;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {ir_in, sr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_q          <= 1'b0;
            uir_q          <= 1'b0;
            ir_update      <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            overflow       <= 1'b0;
            jdo            <= '0;
            cmd_ir         <= '0;
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            udr_q     <= udr_s;
            uir_q     <= uir_s;
            ir_update <= uir_s & ~uir_q;

            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;

            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;

            take_action    <= '0;
            take_no_action <= '0;
            if (pop) begin
                jdo    <= head.sr;
                cmd_ir <= head.ir;
                if (head.sr[SR_W-1]) take_action    <= head_onehot;
                else                 take_no_action <= head_onehot;
            end
        end
    end

endmodule
